mandelbrot_multi_solver: RTL and testbench

Parallel Mandelbrot escape-time engine: scans a rectangular region of the complex plane in raster order and dispatches each pixel to one of N iterative solver cores. Finished results are merged into a single ready/valid result stream. It sits between the frame-configuration registers (region bounds and step) and the pixel writer / framebuffer path.

---
 rtl/mandelbrot_multi_solver_pkg.sv | 24 ++
 rtl/mandelbrot_multi_solver_core.sv | 105 ++++++++++
 rtl/mandelbrot_multi_solver.sv | 221 ++++++++++++++++++++++
 tb/tb_mandelbrot_multi_solver.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mandelbrot_multi_solver_pkg.sv
// Shared definitions for the Mandelbrot multi-solver engine.
// Fixed-point format is signed Q6.20 (27 bits). Squared terms are carried at
// full 54-bit precision for the escape test. Also defines the pixel index width,
// the iteration count width and the per-core state encoding.
package mandelbrot_multi_solver_pkg;

  localparam int FX_W   = 27;
  localparam int FRAC_W = 20;
  localparam int PROD_W = 2 * FX_W;
  localparam int MAG_W  = PROD_W + 1;
  localparam int IDX_W  = 12;
  localparam int ITER_W = 8;

  // Escape radius squared, 4.0, at Q6.20 and at product scale (Q12.40).
  localparam logic signed [FX_W-1:0]  ESC_Q    = 27'sd4 <<< FRAC_W;
  localparam logic signed [MAG_W-1:0] ESC_PROD = 55'sd4 <<< (2 * FRAC_W);

  typedef enum logic [1:0] {
    CS_IDLE = 2'd0,
    CS_RUN  = 2'd1,
    CS_DONE = 2'd2
  } core_state_e;

endpackage

// File: rtl/mandelbrot_multi_solver_core.sv
// mandelbrot_core: one iterative escape-time solver.
// Ports:
//   clock, reset      clock and asynchronous active-high reset
//   start_i           assign a pixel (only honoured while IDLE)
//   cr_i, ci_i        pixel coordinate c, Q6.20
//   col_i, row_i      pixel index, carried through to the result
//   accept_i          result taken by the output arbiter (DONE -> IDLE)
//   state_o           IDLE / RUN / DONE
//   col_o, row_o      index of the pixel held by this core
//   iter_o            escape count, valid in DONE
module mandelbrot_core
  import mandelbrot_multi_solver_pkg::*;
#(
  parameter int MAX_ITER = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic signed [FX_W-1:0]  cr_i,
  input  logic signed [FX_W-1:0]  ci_i,
  input  logic [IDX_W-1:0]        col_i,
  input  logic [IDX_W-1:0]        row_i,
  input  logic                    accept_i,
  output core_state_e             state_o,
  output logic [IDX_W-1:0]        col_o,
  output logic [IDX_W-1:0]        row_o,
  output logic [ITER_W-1:0]       iter_o
);

  core_state_e              state_q, state_d;
  logic [ITER_W-1:0]        cnt_q, cnt_d;
  logic signed [FX_W-1:0]   zr_q, zi_q, cr_q, ci_q;
  logic [IDX_W-1:0]         col_q, row_q;

  logic signed [PROD_W-1:0] p_rr, p_ii, p_ri;
  logic signed [MAG_W-1:0]  mag;
  logic signed [FX_W-1:0]   ri, zr_nx, zi_nx;
  logic                     escape, last;

  // Product back to Q6.20: arithmetic shift, keep the low 27 bits.
  function automatic logic signed [FX_W-1:0] fx_trunc(input logic signed [PROD_W-1:0] p);
    return FX_W'(p >>> FRAC_W);
  endfunction

  // The load cycle writes z1 = c directly (z0 = 0), so the register always
  // holds z_n with n = cnt_q and the escape test runs on that register.
  always_comb begin
    p_rr   = PROD_W'(zr_q) * PROD_W'(zr_q);
    p_ii   = PROD_W'(zi_q) * PROD_W'(zi_q);
    p_ri   = PROD_W'(zr_q) * PROD_W'(zi_q);
    mag    = MAG_W'(p_rr) + MAG_W'(p_ii);
    escape = mag > ESC_PROD;
    last   = escape || (cnt_q == ITER_W'(MAX_ITER));
    ri     = fx_trunc(p_ri);
    zr_nx  = fx_trunc(p_rr) - fx_trunc(p_ii) + cr_q;
    zi_nx  = (ri <<< 1) + ci_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CS_IDLE: if (start_i) begin
        state_d = CS_RUN;
        cnt_d   = ITER_W'(1);
      end
      CS_RUN: begin
        if (last) state_d = CS_DONE;
        else      cnt_d   = cnt_q + 1'b1;
      end
      CS_DONE: if (accept_i) state_d = CS_IDLE;
      default: state_d = CS_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= CS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (state_q == CS_IDLE && start_i) begin
      cr_q  <= cr_i;
      ci_q  <= ci_i;
      zr_q  <= cr_i;
      zi_q  <= ci_i;
      col_q <= col_i;
      row_q <= row_i;
    end else if (state_q == CS_RUN && !last) begin
      zr_q <= zr_nx;
      zi_q <= zi_nx;
    end
  end

  assign state_o = state_q;
  assign col_o   = col_q;
  assign row_o   = row_q;
  assign iter_o  = cnt_q;

endmodule

// File: rtl/mandelbrot_multi_solver.sv
// mandelbrot_multi_solver: raster scan of a complex-plane region dispatched to
// N mandelbrot_core instances; results merged round-robin into one ready/valid
// stream (completion order, not raster order).
// Ports:
//   clock, reset                  clock, asynchronous active-high reset
//   min_x/min_y, max_x/max_y      region bounds, signed Q6.20, inclusive
//   dx, dy                        unsigned Q6.20 steps
//   out_valid/out_ready           result handshake
//   out_col, out_row, out_iter    pixel index and escape count
//   done                          frame scanned and all results drained
// Optional build macro MULTI_SOLVER_STATS_EN adds cycle_count and iter_total
// (32-bit, saturating).
module mandelbrot_multi_solver
  import mandelbrot_multi_solver_pkg::*;
#(
  parameter int N        = 1,
  parameter int MAX_ITER = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic signed [FX_W-1:0]  min_x,
  input  logic signed [FX_W-1:0]  min_y,
  input  logic signed [FX_W-1:0]  max_x,
  input  logic signed [FX_W-1:0]  max_y,
  input  logic [FX_W-1:0]         dx,
  input  logic [FX_W-1:0]         dy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        out_col,
  output logic [IDX_W-1:0]        out_row,
  output logic [ITER_W-1:0]       out_iter,
  output logic                    done
`ifdef MULTI_SOLVER_STATS_EN
  ,
  output logic [31:0]             cycle_count,
  output logic [31:0]             iter_total
`endif
);

  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int CW1 = CW + 1;
  localparam int SW  = FX_W + 1;

  // Scan state
  logic                   started_q, scan_done_q;
  logic [IDX_W-1:0]       col_q, row_q;
  logic signed [FX_W-1:0] min_x_q, max_x_q, max_y_q, cr_q, ci_q;
  logic [FX_W-1:0]        dx_q, dy_q;
  logic signed [SW-1:0]   cr_step, ci_step;
  logic                   row_end, frame_end, pix_vld, dispatch;

  // Core side
  core_state_e            core_st   [N];
  logic [IDX_W-1:0]       core_col  [N];
  logic [IDX_W-1:0]       core_row  [N];
  logic [ITER_W-1:0]      core_iter [N];
  logic [N-1:0]           assign_vec, idle_vec, done_vec, accept_vec;
  logic                   found;

  // Arbiter / output register
  logic [CW-1:0]          rr_q, grant_idx;
  logic [CW1-1:0]         cand;
  logic                   grant_vld, out_load;
  logic                   out_valid_q, done_q;
  logic [IDX_W-1:0]       out_col_q, out_row_q;
  logic [ITER_W-1:0]      out_iter_q;

  // Next scan position; one extra bit so stepping past the top of the
  // Q6.20 range still compares correctly against the bound.
  always_comb begin
    cr_step   = SW'(cr_q) + $signed({1'b0, dx_q});
    ci_step   = SW'(ci_q) + $signed({1'b0, dy_q});
    row_end   = cr_step > SW'(max_x_q);
    frame_end = row_end && (ci_step > SW'(max_y_q));
    pix_vld   = started_q && !scan_done_q;
    dispatch  = pix_vld && (|idle_vec);
  end

  // Scan control. The first clock with reset low latches the bounds.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      started_q   <= 1'b0;
      scan_done_q <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
    end else if (!started_q) begin
      started_q   <= 1'b1;
      scan_done_q <= (min_x > max_x) || (min_y > max_y);
    end else if (dispatch) begin
      if (!row_end) begin
        col_q <= col_q + 1'b1;
      end else begin
        col_q <= '0;
        if (frame_end) scan_done_q <= 1'b1;
        else           row_q       <= row_q + 1'b1;
      end
    end
  end

  // Configuration and scan coordinates (data only, follow the inputs until
  // the scan starts).
  always_ff @(posedge clock) begin
    if (!started_q) begin
      min_x_q <= min_x;
      max_x_q <= max_x;
      max_y_q <= max_y;
      dx_q    <= dx;
      dy_q    <= dy;
      cr_q    <= min_x;
      ci_q    <= min_y;
    end else if (dispatch) begin
      if (!row_end) begin
        cr_q <= FX_W'(cr_step);
      end else begin
        cr_q <= min_x_q;
        if (!frame_end) ci_q <= FX_W'(ci_step);
      end
    end
  end

  // Dispatcher: lowest-index idle core takes the current pixel.
  always_comb begin
    assign_vec = '0;
    found      = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (pix_vld && !found && idle_vec[i]) begin
        assign_vec[i] = 1'b1;
        found         = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_core
    mandelbrot_core #(.MAX_ITER(MAX_ITER)) u_core (
      .clock    (clock),
      .reset    (reset),
      .start_i  (assign_vec[g]),
      .cr_i     (cr_q),
      .ci_i     (ci_q),
      .col_i    (col_q),
      .row_i    (row_q),
      .accept_i (accept_vec[g]),
      .state_o  (core_st[g]),
      .col_o    (core_col[g]),
      .row_o    (core_row[g]),
      .iter_o   (core_iter[g])
    );
    assign idle_vec[g]   = (core_st[g] == CS_IDLE);
    assign done_vec[g]   = (core_st[g] == CS_DONE);
    assign accept_vec[g] = out_load && (grant_idx == CW'(g));
  end

  // Round-robin search starting just after the last granted core.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, rr_q} + CW1'(i + 1);
      if (cand >= CW1'(N)) cand = cand - CW1'(N);
      if (!grant_vld && done_vec[cand[CW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[CW-1:0];
      end
    end
    // Reload in the same cycle the current result is accepted.
    out_load = grant_vld && (!out_valid_q || out_ready);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
      out_row_q   <= '0;
      out_iter_q  <= '0;
      rr_q        <= '0;
      done_q      <= 1'b0;
    end else begin
      if (out_load) begin
        out_valid_q <= 1'b1;
        out_col_q   <= core_col[grant_idx];
        out_row_q   <= core_row[grant_idx];
        out_iter_q  <= core_iter[grant_idx];
        rr_q        <= grant_idx;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (started_q && scan_done_q && (&idle_vec) && !out_valid_q) done_q <= 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_col   = out_col_q;
  assign out_row   = out_row_q;
  assign out_iter  = out_iter_q;
  assign done      = done_q;

`ifdef MULTI_SOLVER_STATS_EN
  logic [31:0] cyc_q, itot_q;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cyc_q  <= '0;
      itot_q <= '0;
    end else begin
      if (!done_q) cyc_q <= sat_add(cyc_q, 32'd1);
      if (out_valid_q && out_ready) itot_q <= sat_add(itot_q, 32'(out_iter_q));
    end
  end

  assign cycle_count = cyc_q;
  assign iter_total  = itot_q;
`endif

endmodule

// File: tb/tb_mandelbrot_multi_solver.sv
module tb_mandelbrot_multi_solver;

  localparam int     N        = 4;
  localparam int     MAX_ITER = 255;
  localparam longint ONE      = 64'sd1 << 20;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic signed [26:0] min_x = '0, min_y = '0, max_x = '0, max_y = '0;
  logic [26:0]        dx = '0, dy = '0;
  logic               out_valid, out_ready = 1'b1, done;
  logic [11:0]        out_col, out_row;
  logic [7:0]         out_iter;
`ifdef MULTI_SOLVER_STATS_EN
  logic [31:0]        cycle_count, iter_total;
`endif

  mandelbrot_multi_solver #(.N(N), .MAX_ITER(MAX_ITER)) dut (
    .clock     (clock),
    .reset     (reset),
    .min_x     (min_x),
    .min_y     (min_y),
    .max_x     (max_x),
    .max_y     (max_y),
    .dx        (dx),
    .dy        (dy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_row   (out_row),
    .out_iter  (out_iter),
    .done      (done)
`ifdef MULTI_SOLVER_STATS_EN
    ,
    .cycle_count (cycle_count),
    .iter_total  (iter_total)
`endif
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  longint f_min_x, f_min_y, f_max_x, f_max_y, f_dx, f_dy;
  int     exp_iter [int];
  int     seen     [int];

  typedef struct {
    longint mnx, mny, mxx, mxy, sx, sy;
    int     exp_cnt;
    int     exp_iter0;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic longint wrap27(input longint v);
    return (v <<< 37) >>> 37;
  endfunction

  // Escape-time reference: iterate z <- z^2 + c from z0 = 0 with the
  // truncated fixed-point products, test |z_n|^2 > 4 at full precision.
  function automatic int ref_iter(input longint cr, input longint ci);
    longint zr, zi, nr, ni;
    zr = 0;
    zi = 0;
    for (int n = 1; n <= MAX_ITER; n++) begin
      nr = wrap27(wrap27((zr * zr) >>> 20) - wrap27((zi * zi) >>> 20) + cr);
      ni = wrap27(2 * wrap27((zr * zi) >>> 20) + ci);
      zr = nr;
      zi = ni;
      if (zr * zr + zi * zi > (64'sd4 << 40)) return n;
    end
    return MAX_ITER;
  endfunction

  task automatic build_expected(output int cnt);
    cnt = 0;
    exp_iter.delete();
    seen.delete();
    if (f_min_x <= f_max_x && f_min_y <= f_max_y) begin
      for (int r = 0; f_min_y + r * f_dy <= f_max_y; r++)
        for (int c = 0; f_min_x + c * f_dx <= f_max_x; c++) begin
          exp_iter[c * 4096 + r] = ref_iter(f_min_x + c * f_dx, f_min_y + r * f_dy);
          cnt++;
        end
    end
  endtask

  task automatic start_frame(input longint a, input longint b, input longint c,
                             input longint d, input longint e, input longint f);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("valid_low_in_reset", out_valid, 0);
    f_min_x = a; f_min_y = b; f_max_x = c; f_max_y = d; f_dx = e; f_dy = f;
    min_x = 27'(a); min_y = 27'(b); max_x = 27'(c); max_y = 27'(d);
    dx = 27'(e); dy = 27'(f);
    @(negedge clock);
    @(negedge clock);
    check("rst_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_out", {out_col, out_row, out_iter}, 0);
    reset = 1'b0;
  endtask

  task automatic run_frame(input bit rnd, input int budget,
                           output int got, output int it00, output int lat);
    int          cyc, key, ecnt;
    bit          stalled;
    logic [32:0] held, now;
    build_expected(ecnt);
    got = 0; it00 = -1; lat = -1; cyc = 0; stalled = 0; held = '0;
    while (cyc < budget) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        // Bounds are already latched; later input changes must be ignored.
        min_x = 27'($urandom); max_x = 27'($urandom); min_y = 27'($urandom);
        max_y = 27'($urandom); dx = 27'($urandom); dy = 27'($urandom);
      end
      now = {out_valid, out_col, out_row, out_iter};
      if (stalled) check("hold_while_stalled", now, held);
      if (done) break;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && lat < 0) lat = cyc;
      if (out_valid && out_ready) begin
        key = int'(out_col) * 4096 + int'(out_row);
        got++;
        check($sformatf("dup(%0d,%0d)", out_col, out_row), seen.exists(key) ? 1 : 0, 0);
        seen[key] = 1;
        check($sformatf("iter(%0d,%0d)", out_col, out_row), out_iter,
              exp_iter.exists(key) ? exp_iter[key] : -1);
        if (key == 0) it00 = int'(out_iter);
      end
      stalled = out_valid && !out_ready;
      held    = now;
    end
    check("done_reached", done, 1);
    check("result_count", got, ecnt);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t   tbl [5];
    int     lats [5];
    int     got, it00, lat, nc, nr;
    longint mx, my, sx, sy;

    tbl[0] = '{0, 0, 0, 0, ONE, ONE, 1, 255};
    tbl[1] = '{ONE, ONE, ONE, ONE, ONE, ONE, 1, 2};
    tbl[2] = '{-2 * ONE, -ONE, -2 * ONE, -ONE, ONE, ONE, 1, 1};
    tbl[3] = '{-2 * ONE, -ONE, ONE, ONE, ONE, ONE, 12, 1};
    tbl[4] = '{-ONE / 2, 0, ONE / 4, 0, ONE / 4, ONE / 4, 4, 255};

    for (int i = 0; i < 5; i++) begin
      start_frame(tbl[i].mnx, tbl[i].mny, tbl[i].mxx, tbl[i].mxy, tbl[i].sx, tbl[i].sy);
      run_frame(0, 3000, got, it00, lat);
      check($sformatf("tbl%0d_count", i), got, tbl[i].exp_cnt);
      check($sformatf("tbl%0d_iter00", i), it00, tbl[i].exp_iter0);
      lats[i] = lat;
`ifdef MULTI_SOLVER_STATS_EN
      if (i == 0) begin
        check("iter_total", iter_total, 255);
        check("cycle_count_ge_257", (cycle_count >= 257) ? 1 : 0, 1);
      end
`endif
    end

    // Each extra iteration adds exactly one cycle of latency.
    check("latency_255_vs_1", lats[0] - lats[2], 254);
    check("latency_2_vs_1", lats[1] - lats[2], 1);

    // Random small regions with a randomly stalling consumer.
    for (int k = 0; k < 6; k++) begin
      sx = longint'($urandom_range(1 << 16, 1 << 19));
      sy = longint'($urandom_range(1 << 16, 1 << 19));
      nc = $urandom_range(1, 6);
      nr = $urandom_range(1, 5);
      mx = longint'($urandom_range(0, 3670016)) - 2621440;
      my = longint'($urandom_range(0, 2621440)) - 1572864;
      start_frame(mx, my, mx + (nc - 1) * sx + longint'($urandom_range(0, 32'(sx - 1))),
                  my + (nr - 1) * sy + longint'($urandom_range(0, 32'(sy - 1))), sx, sy);
      run_frame(1, 6000, got, it00, lat);
    end

    // Reset in the middle of a large frame, restart on a single pixel.
    start_frame(-2 * ONE, -ONE, ONE, ONE, ONE / 8, ONE / 8);
    repeat (60) begin
      @(negedge clock);
      out_ready = 1'($urandom_range(0, 1));
    end
    start_frame(ONE, ONE, ONE, ONE, ONE, ONE);
    run_frame(1, 2000, got, it00, lat);
    check("after_reset_count", got, 1);
    check("after_reset_iter00", it00, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
